set_time_controller: RTL

Sequences the stopwatch's set-number path. It takes debounced single-cycle button pulses and lets the user edit a four-digit MM:SS preset one digit at a time, with the selected digit blinking. On commit it emits a one-cycle load strobe carrying the preset digits to the stopwatch counter. It sits between the button debouncers and the timekeeping counter, and its digit and blink outputs drive the seven-segment display mux.

---
 rtl/stopwatch_pkg.sv | 26 ++
 rtl/blink_timer.sv | 46 ++++
 rtl/set_time_controller.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch set-number path.
package stopwatch_pkg;

    // Controller state encoding
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EDIT   = 2'd1,
        COMMIT = 2'd2
    } state_e;

    // Largest legal value for tens and ones digits
    localparam logic [3:0] TENS_MAX = 4'd5;
    localparam logic [3:0] ONES_MAX = 4'd9;

    // Digit select indices, most significant digit first
    localparam logic [1:0] SEL_MIN_TENS = 2'd3;
    localparam logic [1:0] SEL_MIN_ONES = 2'd2;
    localparam logic [1:0] SEL_SEC_TENS = 2'd1;
    localparam logic [1:0] SEL_SEC_ONES = 2'd0;

    // Increment a digit, wrapping to zero past its limit
    function automatic logic [3:0] digit_inc(input logic [3:0] d, input logic [3:0] max);
        return (d >= max) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/blink_timer.sv
// Blink generator for the selected digit: toggles every DIV cycles while enabled.
module blink_timer #(
    parameter int unsigned DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    output logic blink
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          blink_q, blink_d;

    // Next-state: hold cleared when disabled, restart keeps the digit visible
    always_comb begin
        cnt_d   = cnt_q;
        blink_d = blink_q;
        if (!en || restart) begin
            cnt_d   = '0;
            blink_d = 1'b0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d   = '0;
            blink_d = ~blink_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter and blink state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            blink_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            blink_q <= blink_d;
        end
    end

    assign blink = blink_q;

endmodule

// File: rtl/set_time_controller.sv
// MM:SS preset editor: edits a working copy digit by digit and commits it
// to the committed bank with a one-cycle load strobe.
module set_time_controller #(
    parameter int unsigned BLINK_DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_req,
    input  logic       inc,
    input  logic       next,
    input  logic       cancel,
    input  logic       run,
    output logic [2:0] min_tens,
    output logic [3:0] min_ones,
    output logic [2:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [1:0] sel,
    output logic       set_active,
    output logic       blink,
    output logic       load
);

    import stopwatch_pkg::*;

    state_e     state_q, state_d;
    logic [1:0] sel_q, sel_d;

    // Committed bank
    logic [2:0] c_mt_q, c_mt_d;
    logic [3:0] c_mo_q, c_mo_d;
    logic [2:0] c_st_q, c_st_d;
    logic [3:0] c_so_q, c_so_d;

    // Working bank
    logic [2:0] w_mt_q, w_mt_d;
    logic [3:0] w_mo_q, w_mo_d;
    logic [2:0] w_st_q, w_st_d;
    logic [3:0] w_so_q, w_so_d;

    // Registered outputs
    logic [2:0] disp_mt_q;
    logic [3:0] disp_mo_q;
    logic [2:0] disp_st_q;
    logic [3:0] disp_so_q;
    logic       set_active_q;
    logic       load_q;

    logic       blink_restart;
    logic       blink_en;
    logic       edit_d;

    // State and bank next-state; in EDIT abort beats commit beats next beats inc
    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        c_mt_d        = c_mt_q;
        c_mo_d        = c_mo_q;
        c_st_d        = c_st_q;
        c_so_d        = c_so_q;
        w_mt_d        = w_mt_q;
        w_mo_d        = w_mo_q;
        w_st_d        = w_st_q;
        w_so_d        = w_so_q;
        blink_restart = 1'b0;
        case (state_q)
            IDLE: begin
                if (set_req && !run) begin
                    state_d       = EDIT;
                    sel_d         = SEL_MIN_TENS;
                    w_mt_d        = c_mt_q;
                    w_mo_d        = c_mo_q;
                    w_st_d        = c_st_q;
                    w_so_d        = c_so_q;
                    blink_restart = 1'b1;
                end
            end
            EDIT: begin
                if (cancel || run) begin
                    // Working copy is simply left stale; the display reverts to C
                    state_d = IDLE;
                end else if (set_req) begin
                    state_d = COMMIT;
                    c_mt_d  = w_mt_q;
                    c_mo_d  = w_mo_q;
                    c_st_d  = w_st_q;
                    c_so_d  = w_so_q;
                end else if (next) begin
                    // 2-bit subtract wraps 0 -> 3 on its own
                    sel_d         = sel_q - 2'd1;
                    blink_restart = 1'b1;
                end else if (inc) begin
                    blink_restart = 1'b1;
                    unique case (sel_q)
                        SEL_MIN_TENS: w_mt_d = 3'(digit_inc({1'b0, w_mt_q}, TENS_MAX));
                        SEL_MIN_ONES: w_mo_d = digit_inc(w_mo_q, ONES_MAX);
                        SEL_SEC_TENS: w_st_d = 3'(digit_inc({1'b0, w_st_q}, TENS_MAX));
                        SEL_SEC_ONES: w_so_d = digit_inc(w_so_q, ONES_MAX);
                        default: ;
                    endcase
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign edit_d   = (state_d == EDIT);
    assign blink_en = edit_d;

    // State, banks and registered outputs; outputs track the next state so
    // they line up with the state they describe
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sel_q        <= SEL_MIN_TENS;
            c_mt_q       <= '0;
            c_mo_q       <= '0;
            c_st_q       <= '0;
            c_so_q       <= '0;
            w_mt_q       <= '0;
            w_mo_q       <= '0;
            w_st_q       <= '0;
            w_so_q       <= '0;
            disp_mt_q    <= '0;
            disp_mo_q    <= '0;
            disp_st_q    <= '0;
            disp_so_q    <= '0;
            set_active_q <= 1'b0;
            load_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            c_mt_q       <= c_mt_d;
            c_mo_q       <= c_mo_d;
            c_st_q       <= c_st_d;
            c_so_q       <= c_so_d;
            w_mt_q       <= w_mt_d;
            w_mo_q       <= w_mo_d;
            w_st_q       <= w_st_d;
            w_so_q       <= w_so_d;
            disp_mt_q    <= edit_d ? w_mt_d : c_mt_d;
            disp_mo_q    <= edit_d ? w_mo_d : c_mo_d;
            disp_st_q    <= edit_d ? w_st_d : c_st_d;
            disp_so_q    <= edit_d ? w_so_d : c_so_d;
            set_active_q <= edit_d;
            load_q       <= (state_d == COMMIT);
        end
    end

    blink_timer #(
        .DIV(BLINK_DIV)
    ) u_blink_timer (
        .clk    (clk),
        .rst    (rst),
        .en     (blink_en),
        .restart(blink_restart),
        .blink  (blink)
    );

    assign min_tens   = disp_mt_q;
    assign min_ones   = disp_mo_q;
    assign sec_tens   = disp_st_q;
    assign sec_ones   = disp_so_q;
    assign sel        = sel_q;
    assign set_active = set_active_q;
    assign load       = load_q;

endmodule
